// File: rtl/mem_debug_dumper.sv
// Walks TAM_M data-memory words through the MEM-stage debug read port and
// streams each word, MSB byte first, over a valid/ready byte link.
module mem_debug_dumper #(
   parameter int NBITS = 32,
   parameter int TAM_M = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   output logic [NBITS-1:0] o_mem_debug_addr,
   input  logic [NBITS-1:0] i_mem_debug_data,
   output logic [7:0]       o_tx_data,
   output logic             o_tx_valid,
   input  logic             i_tx_ready,
   output logic             o_busy,
   output logic             o_done
);

   localparam int IDX_W = (TAM_M > 1) ? $clog2(TAM_M) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAM_M - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_READ    = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_SEND    = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   logic [2:0]       state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [1:0]       cnt_reg, cnt_next;
   logic [NBITS-1:0] word_reg, word_next;
   logic [7:0]       lane [4];

   // Byte lanes of the latched word, lane 0 being the most significant byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
         assign lane[gi] = word_reg[NBITS-1-8*gi -: 8];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      word_next  = word_reg;
      case (state_reg)
         ST_IDLE: begin
            if (i_start) begin
               state_next = ST_READ;
               idx_next   = '0;
            end
         end
         ST_READ: begin
            state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            word_next  = i_mem_debug_data;
            cnt_next   = 2'd0;
            state_next = ST_SEND;
         end
         ST_SEND: begin
            if (i_tx_ready) begin
               if (cnt_reg == 2'd3) begin
                  // Last byte of the word: either finish or fetch the next word.
                  if (idx_reg == LAST_IDX) begin
                     state_next = ST_DONE;
                  end else begin
                     idx_next   = idx_reg + IDX_W'(1);
                     state_next = ST_READ;
                  end
               end else begin
                  cnt_next = cnt_reg + 2'd1;
               end
            end
         end
         ST_DONE: begin
            idx_next   = '0;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         cnt_reg   <= 2'd0;
         word_reg  <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         word_reg  <= word_next;
      end
   end

   // Outputs decode registered state only, so reset clears them without a clock.
   assign o_mem_debug_addr = NBITS'(idx_reg);
   assign o_tx_valid       = (state_reg == ST_SEND);
   assign o_tx_data        = o_tx_valid ? lane[cnt_reg] : 8'h00;
   assign o_busy           = (state_reg == ST_READ) || (state_reg == ST_CAPTURE) ||
                             (state_reg == ST_SEND);
   assign o_done           = (state_reg == ST_DONE);

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Directed bench for mem_debug_dumper: a byte scoreboard fed at dump start and
// drained by a monitor on every accepted byte, plus timing/handshake checks.
`timescale 1ns/1ps
module tb_mem_debug_dumper;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_start = 1'b0;
   logic        i_tx_ready = 1'b0;
   logic [31:0] o_mem_debug_addr;
   logic [31:0] i_mem_debug_data = 32'h0;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid, o_busy, o_done;

   int vectors = 0;
   int miscompares = 0;
   int edge_cnt = 0;
   int done_cnt = 0;
   int done_edge = 0;
   int byte_cnt = 0;
   int byte_in_run = 0;
   int busy_cycles = 0;
   int gap_cycles = 0;
   logic [7:0] exp_q [$];

   mem_debug_dumper #(.NBITS(32), .TAM_M(10)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_start          (i_start),
      .o_mem_debug_addr (o_mem_debug_addr),
      .i_mem_debug_data (i_mem_debug_data),
      .o_tx_data        (o_tx_data),
      .o_tx_valid       (o_tx_valid),
      .i_tx_ready       (i_tx_ready),
      .o_busy           (o_busy),
      .o_done           (o_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Data memory with one-cycle read latency: word k holds 0x11223300 + k.
   always @(posedge clk) i_mem_debug_data <= 32'h11223300 + o_mem_debug_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: sampled mid-cycle, so valid&ready here means a transfer at the next edge.
   always @(negedge clk) begin
      if (reset) begin
         if (o_busy) busy_cycles++;
         if (o_busy && !o_tx_valid) gap_cycles++;
         if (o_done) begin
            done_cnt++;
            done_edge = edge_cnt;
         end
         if (o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $error("FAIL unexpected_byte: observed %0h expected no byte", o_tx_data);
            end else begin
               check("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_q.pop_front()});
               check("byte_addr", o_mem_debug_addr, byte_in_run / 4);
            end
            byte_in_run = (byte_in_run + 1) % 40;
            byte_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_dump();
      logic [31:0] word;
      for (int w = 0; w < 10; w++) begin
         word = 32'h11223300 + w;
         for (int b = 0; b < 4; b++) exp_q.push_back(word[31-8*b -: 8]);
      end
   endtask

   task automatic pulse_start(output int s_edge);
      i_start = 1'b1;
      s_edge  = edge_cnt + 1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      int n;
      n = 0;
      while (done_cnt < target && n < 400) begin
         tick();
         n++;
      end
      check({tag, "_done_count"}, done_cnt, target);
   endtask

   initial begin
      int s;
      int d1;
      int e0;
      int n;

      // Reset asserted from time zero: outputs must be cleared before any edge.
      #3;
      check("rst_addr", o_mem_debug_addr, 32'h0);
      check("rst_tx_data", {24'h0, o_tx_data}, 32'h0);
      check("rst_valid", {31'h0, o_tx_valid}, 32'h0);
      check("rst_busy", {31'h0, o_busy}, 32'h0);
      check("rst_done", {31'h0, o_done}, 32'h0);
      tick();
      tick();
      reset = 1'b1;
      repeat (3) tick();
      check("idle_busy", {31'h0, o_busy}, 32'h0);
      check("idle_valid", {31'h0, o_tx_valid}, 32'h0);

      // Full dump with the transmitter always ready.
      i_tx_ready  = 1'b1;
      busy_cycles = 0;
      gap_cycles  = 0;
      byte_cnt    = 0;
      byte_in_run = 0;
      push_dump();
      pulse_start(s);
      wait_done(1, "full");
      // o_done appears after edge s+60, i.e. the 61st edge counting the sampling edge.
      check("full_done_latency", done_edge - s, 60);
      check("full_bytes", byte_cnt, 40);
      check("full_queue_left", exp_q.size(), 0);
      check("full_busy_cycles", busy_cycles, 60);
      check("full_gap_cycles", gap_cycles, 20);
      check("full_addr_after_done", o_mem_debug_addr, 32'h0);
      check("full_busy_after_done", {31'h0, o_busy}, 32'h0);

      // Backpressure on byte 2 of word 0 for five cycles.
      byte_cnt = 0;
      push_dump();
      pulse_start(s);
      n = 0;
      while (!(o_tx_valid && byte_cnt == 2) && n < 50) begin
         tick();
         n++;
      end
      check("bp_reached_byte2", byte_cnt, 2);
      i_tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_data", {24'h0, o_tx_data}, 32'h33);
         check("bp_hold_valid", {31'h0, o_tx_valid}, 32'h1);
         tick();
      end
      check("bp_after_hold_data", {24'h0, o_tx_data}, 32'h33);
      i_tx_ready = 1'b1;
      wait_done(2, "bp");
      check("bp_done_latency", done_edge - s, 65);
      check("bp_bytes", byte_cnt, 40);
      check("bp_queue_left", exp_q.size(), 0);

      // i_start pulsed while word 3 is being sent must be ignored.
      byte_cnt = 0;
      push_dump();
      pulse_start(s);
      n = 0;
      while (!(o_tx_valid && byte_cnt == 13) && n < 100) begin
         tick();
         n++;
      end
      check("ign_reached_word3", o_mem_debug_addr, 32'd3);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      wait_done(3, "ign");
      repeat (5) tick();
      check("ign_done_total", done_cnt, 3);
      check("ign_bytes", byte_cnt, 40);
      check("ign_busy_after", {31'h0, o_busy}, 32'h0);
      check("ign_queue_left", exp_q.size(), 0);

      // i_start held high: a second dump follows straight after DONE.
      byte_cnt = 0;
      push_dump();
      push_dump();
      i_start = 1'b1;
      s = edge_cnt + 1;
      wait_done(4, "held1");
      d1 = done_edge;
      check("held_first_latency", d1 - s, 60);
      check("held_idle_busy", {31'h0, o_busy}, 32'h0);
      tick();
      check("held_restart_busy", {31'h0, o_busy}, 32'h1);
      check("held_restart_addr", o_mem_debug_addr, 32'h0);
      i_start = 1'b0;
      wait_done(5, "held2");
      check("held_done_spacing", done_edge - d1, 62);
      check("held_bytes", byte_cnt, 80);
      check("held_queue_left", exp_q.size(), 0);

      // Reset mid-dump while a byte is stalled: outputs clear without a clock edge.
      byte_cnt = 0;
      push_dump();
      pulse_start(s);
      n = 0;
      while (!(o_tx_valid && byte_cnt == 5) && n < 50) begin
         tick();
         n++;
      end
      i_tx_ready = 1'b0;
      tick();
      e0 = edge_cnt;
      #2;
      reset = 1'b0;
      #1;
      check("arst_no_edge", edge_cnt, e0);
      check("arst_valid", {31'h0, o_tx_valid}, 32'h0);
      check("arst_busy", {31'h0, o_busy}, 32'h0);
      check("arst_done", {31'h0, o_done}, 32'h0);
      check("arst_addr", o_mem_debug_addr, 32'h0);
      check("arst_tx_data", {24'h0, o_tx_data}, 32'h0);
      exp_q.delete();
      byte_in_run = 0;
      tick();
      tick();
      reset = 1'b1;
      i_tx_ready = 1'b1;
      repeat (10) tick();
      check("arst_idle_busy", {31'h0, o_busy}, 32'h0);
      check("arst_bytes", byte_cnt, 5);
      check("arst_done_total", done_cnt, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
